// File: rtl/game_pkg.sv
// Shared definitions for the game clock path: rate code encoding and the
// button debounce state encoding.
package game_pkg;

  localparam int RATE_W = 2;

  localparam logic [RATE_W-1:0] RATE_FASTEST = 2'b00;
  localparam logic [RATE_W-1:0] RATE_SLOWEST = 2'b11;
  localparam logic [RATE_W-1:0] RATE_DEFAULT = 2'b10;

  typedef enum logic [1:0] {
    LOW       = 2'b00,
    WAIT_HIGH = 2'b01,
    HIGH      = 2'b10,
    WAIT_LOW  = 2'b11
  } db_state_e;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus counting debounce FSM for one raw push-button.
// Emits the debounced level and a single-cycle pulse per accepted press.
module btn_debounce
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             sync0_q, sync1_q;
  db_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync0_q <= 1'b0;
      sync1_q <= 1'b0;
      state_q <= LOW;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync0_q <= btn_raw;
      sync1_q <= sync0_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  // The counter saturates at CNT_MAX by construction: the FSM leaves the
  // waiting state on the same edge the count is found complete.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    unique case (state_q)
      LOW: begin
        if (sync1_q) begin
          state_d = WAIT_HIGH;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT_HIGH: begin
        if (!sync1_q) begin
          state_d = LOW;
          cnt_d   = '0;
        end else if (cnt_q >= CNT_MAX) begin
          state_d = HIGH;
          cnt_d   = '0;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HIGH: begin
        if (!sync1_q) begin
          state_d = WAIT_LOW;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT_LOW: begin
        if (sync1_q) begin
          state_d = HIGH;
          cnt_d   = '0;
        end else if (cnt_q >= CNT_MAX) begin
          state_d = LOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = LOW;
        cnt_d   = '0;
      end
    endcase
    level_d = (state_d == HIGH) || (state_d == WAIT_LOW);
  end

  assign btn_level = level_q;
  assign btn_press = press_q;

endmodule

// File: rtl/speed_ctrl.sv
// Turns faster/slower push-buttons into the saturating 2-bit clk_rate code
// consumed by the game clock divider (00 = fastest, 11 = slowest).
module speed_ctrl
  import game_pkg::*;
#(
  parameter int                DEBOUNCE_CYCLES = 1_000_000,
  parameter logic [RATE_W-1:0] RESET_RATE      = RATE_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn_faster,
  input  logic              btn_slower,
  output logic [RATE_W-1:0] clk_rate,
  output logic              rate_changed
);

  logic              faster_level, faster_press;
  logic              slower_level, slower_press;
  logic [RATE_W-1:0] rate_q, rate_d;
  logic              changed_q, changed_d;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_faster (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_raw   (btn_faster),
    .btn_level (faster_level),
    .btn_press (faster_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_slower (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_raw   (btn_slower),
    .btn_level (slower_level),
    .btn_press (slower_press)
  );

  // Simultaneous requests cancel; saturated requests leave the code alone.
  always_comb begin
    rate_d = rate_q;
    if (faster_press && !slower_press && (rate_q != RATE_FASTEST)) begin
      rate_d = rate_q - RATE_W'(1);
    end else if (slower_press && !faster_press && (rate_q != RATE_SLOWEST)) begin
      rate_d = rate_q + RATE_W'(1);
    end
    changed_d = (rate_d != rate_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rate_q    <= RESET_RATE;
      changed_q <= 1'b0;
    end else begin
      rate_q    <= rate_d;
      changed_q <= changed_d;
    end
  end

  assign clk_rate     = rate_q;
  assign rate_changed = changed_q;

  logic unused_levels;
  assign unused_levels = faster_level ^ slower_level;

endmodule

// File: tb/tb_speed_ctrl.sv
// Directed bench for speed_ctrl with a short debounce window.
module tb_speed_ctrl;

  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_faster = 1'b0;
  logic       btn_slower = 1'b0;
  logic [1:0] clk_rate;
  logic       rate_changed;

  int total = 0;
  int bad   = 0;

  speed_ctrl #(.DEBOUNCE_CYCLES(DB), .RESET_RATE(2'b10)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_faster   (btn_faster),
    .btn_slower   (btn_slower),
    .clk_rate     (clk_rate),
    .rate_changed (rate_changed)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance past the next rising edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    btn_faster = 1'b0;
    btn_slower = 1'b0;
    tick();
    tick();
    chk_eq("reset_rate", {30'd0, clk_rate}, 32'h2);
    chk_eq("reset_rc", {31'd0, rate_changed}, 32'h0);
    rst_n = 1'b1;
  endtask

  logic [1:0] cur, nxt;
  logic [7:0] glitch;

  initial begin
    // Idle after reset
    do_reset();
    for (int k = 0; k < 20; k++) begin
      tick();
      chk_eq("idle_rate", {30'd0, clk_rate}, 32'h2);
      chk_eq("idle_rc", {31'd0, rate_changed}, 32'h0);
    end

    // Slower held for 10 cycles: edge 0 is the next rising edge
    btn_slower = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk_eq("slow_rate", {30'd0, clk_rate}, (k >= 7) ? 32'h3 : 32'h2);
      chk_eq("slow_rc", {31'd0, rate_changed}, (k == 7) ? 32'h1 : 32'h0);
      if (k == 5 || k == 6)
        chk_eq("slow_press", {31'd0, dut.u_slower.btn_press}, (k == 6) ? 32'h1 : 32'h0);
    end
    btn_slower = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk_eq("slow_hold_rate", {30'd0, clk_rate}, 32'h3);
      chk_eq("slow_hold_rc", {31'd0, rate_changed}, 32'h0);
    end

    // Four separate faster presses from 2'b10: 01, 00, 00, 00
    do_reset();
    cur = 2'b10;
    for (int p = 0; p < 4; p++) begin
      nxt = (cur == 2'b00) ? 2'b00 : cur - 2'b01;
      btn_faster = 1'b1;
      for (int k = 0; k < 10; k++) begin
        tick();
        chk_eq("fast_rate", {30'd0, clk_rate}, (k >= 7) ? {30'd0, nxt} : {30'd0, cur});
        chk_eq("fast_rc", {31'd0, rate_changed}, ((k == 7) && (nxt != cur)) ? 32'h1 : 32'h0);
      end
      btn_faster = 1'b0;
      for (int k = 0; k < 10; k++) begin
        tick();
        chk_eq("fast_rel_rate", {30'd0, clk_rate}, {30'd0, nxt});
        chk_eq("fast_rel_rc", {31'd0, rate_changed}, 32'h0);
      end
      cur = nxt;
    end
    chk_eq("fast_final", {30'd0, clk_rate}, 32'h0);

    // Glitchy slower button: 3 high, 2 low, 3 high never accepted
    do_reset();
    glitch = 8'b1110_0111;
    for (int k = 0; k < 20; k++) begin
      btn_slower = (k < 8) ? glitch[7-k] : 1'b0;
      tick();
      chk_eq("glitch_rate", {30'd0, clk_rate}, 32'h2);
      chk_eq("glitch_rc", {31'd0, rate_changed}, 32'h0);
      chk_eq("glitch_press", {31'd0, dut.u_slower.btn_press}, 32'h0);
    end

    // Both buttons together: pulses coincide and cancel
    do_reset();
    btn_faster = 1'b1;
    btn_slower = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk_eq("both_rate", {30'd0, clk_rate}, 32'h2);
      chk_eq("both_rc", {31'd0, rate_changed}, 32'h0);
      chk_eq("both_fpress", {31'd0, dut.u_faster.btn_press}, (k == 6) ? 32'h1 : 32'h0);
      chk_eq("both_spress", {31'd0, dut.u_slower.btn_press}, (k == 6) ? 32'h1 : 32'h0);
    end
    btn_faster = 1'b0;
    btn_slower = 1'b0;

    // Reset at edge 4 while slower is held; full latency restarts after release
    do_reset();
    btn_slower = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    rst_n = 1'b0;
    tick();
    chk_eq("midrst_rate", {30'd0, clk_rate}, 32'h2);
    chk_eq("midrst_rc", {31'd0, rate_changed}, 32'h0);
    chk_eq("midrst_cnt", {30'd0, dut.u_slower.cnt_q}, 32'h0);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk_eq("midrst_after_rate", {30'd0, clk_rate}, (k >= 7) ? 32'h3 : 32'h2);
      chk_eq("midrst_after_rc", {31'd0, rate_changed}, (k == 7) ? 32'h1 : 32'h0);
    end
    btn_slower = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
